// File: rtl/mdu_seq.sv
// Multiply/divide unit with HI/LO registers. MTHI/MTLO take 1 cycle; MULT/DIV results land after MULT_CYCLES/DIV_CYCLES.
// There is no backpressure: ops that arrive while busy are dropped, and stall tells the pipeline to hold.
module mdu_seq #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MULT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] CNT_DIV  = CW'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] a_q, b_q, a_nxt, b_nxt;
  logic [2:0]       op_q, op_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic             busy_nxt;
  logic             is_md;

  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic signed [WIDTH-1:0]   quo_s, rem_s;
  logic        [WIDTH-1:0]   quo_u, rem_u;
  logic                      div_zero, div_ovf;
  logic        [WIDTH-1:0]   res_hi, res_lo;

  assign is_md = start && ((op == OP_MULT) || (op == OP_MULTU) ||
                           (op == OP_DIV)  || (op == OP_DIVU));
  assign stall = busy | is_md;

  // Results are computed combinationally from the latched operands and
  // only committed on the final countdown edge.
  assign prod_s   = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
  assign prod_u   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign quo_s    = $signed(a_q) / $signed(b_q);
  assign rem_s    = $signed(a_q) % $signed(b_q);
  assign quo_u    = a_q / b_q;
  assign rem_u    = a_q % b_q;
  assign div_zero = (b_q == '0);
  assign div_ovf  = (a_q == MOST_NEG) && (b_q == '1);

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (op_q)
      OP_MULT: begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[2*WIDTH-1:WIDTH];
        res_lo = prod_u[WIDTH-1:0];
      end
      OP_DIV: begin
        if (div_zero) begin
          res_hi = a_q;
          res_lo = '1;
        end else if (div_ovf) begin
          res_hi = '0;
          res_lo = a_q;
        end else begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      OP_DIVU: begin
        if (div_zero) begin
          res_hi = a_q;
          res_lo = '1;
        end else begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    a_nxt   = a_q;
    b_nxt   = b_q;
    op_nxt  = op_q;
    hi_nxt  = hi;
    lo_nxt  = lo;
    if (cnt != '0) begin
      cnt_nxt = cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        hi_nxt = res_hi;
        lo_nxt = res_lo;
      end
    end else if (start) begin
      case (op)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
          a_nxt   = A;
          b_nxt   = B;
          op_nxt  = op;
          cnt_nxt = ((op == OP_MULT) || (op == OP_MULTU)) ? CNT_MULT : CNT_DIV;
        end
        OP_MTHI: hi_nxt = A;
        OP_MTLO: lo_nxt = A;
        default: ;
      endcase
    end
    busy_nxt = (cnt_nxt != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      busy <= 1'b0;
    end else begin
      a_q  <= a_nxt;
      b_q  <= b_nxt;
      op_q <= op_nxt;
      cnt  <= cnt_nxt;
      hi   <= hi_nxt;
      lo   <= lo_nxt;
      busy <= busy_nxt;
    end
  end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO width in bits (>=2).
REQ-002 Parameter MULT_CYCLES, default 5, busy length of MULT/MULTU (>=1).
REQ-003 Parameter DIV_CYCLES, default 10, busy length of DIV/DIVU (>=1).
REQ-004 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  sole clock, rising-edge active.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 start  input  1  op-valid strobe, sampled at rising clk.
REQ-008 op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
REQ-009 A  input  WIDTH  first operand / dividend / MTHI-MTLO source.
REQ-010 B  input  WIDTH  second operand / divisor.
REQ-011 hi  output  WIDTH  HI register, registered.
REQ-012 lo  output  WIDTH  LO register, registered.
REQ-013 busy  output  1  operation in progress, registered.
REQ-014 stall  output  1  combinational busy OR (start AND op in 1..4), for the pipeline hazard unit.

Function
REQ-015 Accept: at rising clk, start=1, busy=0, op in 1..4 SHALL latch A, B, op and load the counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
REQ-016 busy SHALL equal (counter != 0); it rises the cycle after the accepting edge and stays high exactly N cycles, N = loaded count.
REQ-017 Each rising clk with counter != 0 SHALL decrement it; the edge taking it 1->0 SHALL write HI/LO, so new hi/lo are visible in the same cycle busy falls.
REQ-018 start with op 1..4 while busy=1 SHALL be ignored: no relatch, no counter reload, no HI/LO change.
REQ-019 MTHI/MTLO with start=1 and busy=0 SHALL write A into HI/LO at that edge, one-cycle latency, busy stays 0.
REQ-020 MTHI/MTLO while busy=1 SHALL be ignored.
REQ-021 start=0, op NONE, or op 7 SHALL leave all state unchanged.
REQ-022 MULT: signed 2*WIDTH product of latched operands; HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-023 MULTU: as REQ-022 with both operands unsigned.
REQ-024 DIV: signed, quotient truncated toward zero into LO, remainder into HI; remainder sign equals dividend sign.
REQ-025 DIVU: unsigned quotient into LO, unsigned remainder into HI.
REQ-026 Divide by zero (DIV/DIVU, B=0): LO = all ones, HI = dividend; busy timing unchanged.
REQ-027 Signed overflow (DIV, A = most negative, B = all ones): LO = A, HI = 0.
REQ-028 Result SHALL depend only on operands latched at accept; A/B changes during busy have no effect.
REQ-029 Multiplier/divider implementation (combinational or iterative) is free provided REQ-016/017 timing holds exactly.

Reset
REQ-030 reset=1 SHALL immediately force hi=0, lo=0, busy=0, counter=0, latched operands/op=0, independent of clk.
REQ-031 Reset asserted mid-operation SHALL abort it; no HI/LO write occurs after reset release.
REQ-032 First accept SHALL be possible on the first rising clk at which reset is low.

Verification (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10)
REQ-033 MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-034 DIV A=-7, B=2 -> busy high 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU A=7, B=2 -> lo=3, hi=1.
REQ-035 DIVU A=0x12345678, B=0 -> after 10 cycles lo=0xFFFFFFFF, hi=0x12345678; DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 MULT 3*4 accepted, MTHI A=0xAA at cycle 2 and DIV at cycle 3 while busy -> both ignored; after 5 cycles hi=0, lo=12; stall=1 throughout busy.
REQ-037 MTLO A=0x55 with busy=0 -> lo=0x55 next cycle, busy=0; MTHI A=0x66 -> hi=0x66.
REQ-038 DIV accepted, reset pulsed (async, mid-cycle) at cycle 4 -> hi=lo=0, busy=0 immediately and remain so; new MULT 2*2 after release -> lo=4 after 5 cycles.
